// File: rtl/mem_arbiter.sv
// Two-to-one arbiter: instruction port and write-buffer data port onto one memory bus.
// Define ARBITER_ROUND_ROBIN_EN for alternating preference; default is data priority with starvation limit.
module mem_arbiter #(
  parameter int starve_limit = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        imem_valid_i,
  input  logic [31:0] imem_addr_i,
  input  logic        imem_fence_i,
  output logic [31:0] imem_rdata_o,
  output logic        imem_ready_o,
  input  logic        dmem_valid_i,
  input  logic [31:0] dmem_addr_i,
  input  logic [31:0] dmem_wdata_i,
  input  logic [3:0]  dmem_wstrb_i,
  input  logic        dmem_fence_i,
  output logic [31:0] dmem_rdata_o,
  output logic        dmem_ready_o,
  output logic        mem_valid_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_wstrb_o,
  output logic        mem_fence_o,
  output logic        mem_instr_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_ready_i
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY_I = 2'd1, BUSY_D = 2'd2} state_t;
  state_t state_q, state_d;

  logic        ipend_q, ifence_q;
  logic [31:0] iaddr_q;
  logic        dpend_q, dfence_q;
  logic [31:0] daddr_q, dwdata_q;
  logic [3:0]  dwstrb_q;

  logic        own_i, own_d, grant_pt;
  logic        i_accept, d_accept, i_cand, d_cand;
  logic        prefer_i, grant_i, grant_d;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic [3:0]  d_wstrb;
  logic        i_fence, d_fence;

  assign own_i    = (state_q == BUSY_I);
  assign own_d    = (state_q == BUSY_D);
  assign grant_pt = rst && ((state_q == IDLE) || mem_ready_i);

  // A pulse is taken only into an empty slot and never while its own transaction still waits for ready.
  assign i_accept = rst && imem_valid_i && !ipend_q && !(own_i && !mem_ready_i);
  assign d_accept = rst && dmem_valid_i && !dpend_q && !(own_d && !mem_ready_i);
  assign i_cand   = ipend_q || i_accept;
  assign d_cand   = dpend_q || d_accept;

  assign i_addr  = ipend_q ? iaddr_q  : imem_addr_i;
  assign i_fence = ipend_q ? ifence_q : imem_fence_i;
  assign d_addr  = dpend_q ? daddr_q  : dmem_addr_i;
  assign d_wdata = dpend_q ? dwdata_q : dmem_wdata_i;
  assign d_wstrb = dpend_q ? dwstrb_q : dmem_wstrb_i;
  assign d_fence = dpend_q ? dfence_q : dmem_fence_i;

  assign grant_i = grant_pt && i_cand && (!d_cand || prefer_i);
  assign grant_d = grant_pt && d_cand && !grant_i;

`ifdef ARBITER_ROUND_ROBIN_EN
  logic rr_q, rr_d;
  assign prefer_i = rr_q;
  assign rr_d     = (grant_pt && i_cand && d_cand) ? ~rr_q : rr_q;

  always_ff @(posedge clk) begin
    if (!rst) rr_q <= 1'b0;
    else      rr_q <= rr_d;
  end
`else
  localparam logic [3:0] LIMIT = 4'(starve_limit);
  logic [3:0] starve_q, starve_d;
  assign prefer_i = (starve_q == LIMIT);

  always_comb begin
    starve_d = starve_q;
    if (grant_i || !i_cand)              starve_d = '0;
    else if (grant_d && starve_q < LIMIT) starve_d = starve_q + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst) starve_q <= '0;
    else      starve_q <= starve_d;
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (grant_pt) begin
      if (grant_i)      state_d = BUSY_I;
      else if (grant_d) state_d = BUSY_D;
      else              state_d = IDLE;
    end
  end

  always_comb begin
    mem_valid_o = 1'b0;
    mem_instr_o = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_wstrb_o = '0;
    mem_fence_o = 1'b0;
    if (grant_i) begin
      mem_valid_o = 1'b1;
      mem_instr_o = 1'b1;
      mem_addr_o  = i_addr;
      mem_fence_o = i_fence;
    end else if (grant_d) begin
      mem_valid_o = 1'b1;
      mem_addr_o  = d_addr;
      mem_wdata_o = d_wdata;
      mem_wstrb_o = d_wstrb;
      mem_fence_o = d_fence;
    end
    imem_ready_o = rst && own_i && mem_ready_i;
    imem_rdata_o = (rst && own_i) ? mem_rdata_i : '0;
    dmem_ready_o = rst && own_d && mem_ready_i;
    dmem_rdata_o = (rst && own_d) ? mem_rdata_i : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ipend_q  <= 1'b0;
      iaddr_q  <= '0;
      ifence_q <= 1'b0;
      dpend_q  <= 1'b0;
      daddr_q  <= '0;
      dwdata_q <= '0;
      dwstrb_q <= '0;
      dfence_q <= 1'b0;
    end else begin
      if (grant_i) begin
        ipend_q <= 1'b0;
      end else if (i_accept) begin
        ipend_q  <= 1'b1;
        iaddr_q  <= imem_addr_i;
        ifence_q <= imem_fence_i;
      end
      if (grant_d) begin
        dpend_q <= 1'b0;
      end else if (d_accept) begin
        dpend_q  <= 1'b1;
        daddr_q  <= dmem_addr_i;
        dwdata_q <= dmem_wdata_i;
        dwstrb_q <= dmem_wstrb_i;
        dfence_q <= dmem_fence_i;
      end
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    assert (!(rst && imem_valid_i && !i_accept))
      else $error("mem_arbiter: imem request while previous one still in flight; dropped");
    assert (!(rst && dmem_valid_i && !d_accept))
      else $error("mem_arbiter: dmem request while previous one still in flight; dropped");
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, priority sequences, then random traffic vs a queue model.
module tb_mem_arbiter;
  localparam int LIMIT = 4;
  localparam int OW = 137;

  logic clk, rst;
  logic imem_valid_i, imem_fence_i, imem_ready_o;
  logic [31:0] imem_addr_i, imem_rdata_o;
  logic dmem_valid_i, dmem_fence_i, dmem_ready_o;
  logic [31:0] dmem_addr_i, dmem_wdata_i, dmem_rdata_o;
  logic [3:0] dmem_wstrb_i;
  logic mem_valid_o, mem_fence_o, mem_instr_o, mem_ready_i;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic [3:0] mem_wstrb_o;

  int nvec = 0;
  int nmis = 0;

  mem_arbiter #(.starve_limit(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .imem_valid_i(imem_valid_i), .imem_addr_i(imem_addr_i), .imem_fence_i(imem_fence_i),
    .imem_rdata_o(imem_rdata_o), .imem_ready_o(imem_ready_o),
    .dmem_valid_i(dmem_valid_i), .dmem_addr_i(dmem_addr_i), .dmem_wdata_i(dmem_wdata_i),
    .dmem_wstrb_i(dmem_wstrb_i), .dmem_fence_i(dmem_fence_i),
    .dmem_rdata_o(dmem_rdata_o), .dmem_ready_o(dmem_ready_o),
    .mem_valid_o(mem_valid_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_wstrb_o(mem_wstrb_o), .mem_fence_o(mem_fence_o), .mem_instr_o(mem_instr_o),
    .mem_rdata_i(mem_rdata_i), .mem_ready_i(mem_ready_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic rs, iv; logic [31:0] ia; logic ifn;
    logic dv; logic [31:0] da, dw; logic [3:0] ds; logic dfn;
    logic mr; logic [31:0] mrd;
    logic ev, ei, ef; logic [31:0] ea, ew; logic [3:0] es;
    logic eir; logic [31:0] eid; logic edr; logic [31:0] edd;
  } vec_t;

  typedef struct packed {
    logic [31:0] addr; logic [31:0] wdata; logic [3:0] wstrb; logic fence; logic instr;
  } txn_t;

  // Reference model state: what each port has waiting and who owns the bus.
  txn_t iq[$];
  txn_t dq[$];
  int m_owner = 0;
`ifdef ARBITER_ROUND_ROBIN_EN
  bit m_rr = 1'b0;
`else
  int m_streak = 0;
`endif

  function automatic vec_t mk(input logic rs, iv, input logic [31:0] ia, input logic ifn,
                              input logic dv, input logic [31:0] da, dw, input logic [3:0] ds,
                              input logic dfn, mr, input logic [31:0] mrd,
                              input logic ev, ei, ef, input logic [31:0] ea, ew,
                              input logic [3:0] es, input logic eir, input logic [31:0] eid,
                              input logic edr, input logic [31:0] edd);
    vec_t v;
    v.rs = rs; v.iv = iv; v.ia = ia; v.ifn = ifn;
    v.dv = dv; v.da = da; v.dw = dw; v.ds = ds; v.dfn = dfn;
    v.mr = mr; v.mrd = mrd;
    v.ev = ev; v.ei = ei; v.ef = ef; v.ea = ea; v.ew = ew; v.es = es;
    v.eir = eir; v.eid = eid; v.edr = edr; v.edd = edd;
    return v;
  endfunction

  function automatic logic [OW-1:0] dut_outs();
    return {mem_valid_o, mem_instr_o, mem_fence_o, mem_addr_o, mem_wdata_o, mem_wstrb_o,
            imem_ready_o, imem_rdata_o, dmem_ready_o, dmem_rdata_o};
  endfunction

  task automatic drive_zero();
    imem_valid_i = 0; imem_addr_i = 0; imem_fence_i = 0;
    dmem_valid_i = 0; dmem_addr_i = 0; dmem_wdata_i = 0; dmem_wstrb_i = 0; dmem_fence_i = 0;
    mem_ready_i = 0; mem_rdata_i = 0;
  endtask

  task automatic apply_check(input logic [OW-1:0] exp, input string name);
    @(negedge clk);
    nvec++;
    if (dut_outs() !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h", name, dut_outs(), exp);
    end
    @(posedge clk); #1;
  endtask

  task automatic seq_check(input logic ev, input logic ei, input string name);
    @(negedge clk);
    nvec++;
    if ({mem_valid_o, mem_instr_o} !== {ev, ei}) begin
      nmis++;
      $display("FAIL %s: got valid/instr %b%b expected %b%b", name, mem_valid_o, mem_instr_o, ev, ei);
    end
    @(posedge clk); #1;
  endtask

  task automatic model_reset();
    iq.delete(); dq.delete(); m_owner = 0;
`ifdef ARBITER_ROUND_ROBIN_EN
    m_rr = 1'b0;
`else
    m_streak = 0;
`endif
  endtask

  task automatic reset_all();
    drive_zero();
    rst = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1;
    model_reset();
  endtask

  task automatic model_step(output logic [OW-1:0] e);
    txn_t t;
    int win;
    bit ic, dc, gt;
    logic mv, mi, mf, ir, dr;
    logic [31:0] ma, mw, id, dd;
    logic [3:0] ms;
    mv = 0; mi = 0; mf = 0; ma = 0; mw = 0; ms = 0; ir = 0; id = 0; dr = 0; dd = 0;
    t = '0;
    if (!rst) begin
      model_reset();
      e = '0;
      return;
    end
    if (m_owner == 1) begin ir = mem_ready_i; id = mem_rdata_i; end
    if (m_owner == 2) begin dr = mem_ready_i; dd = mem_rdata_i; end
    gt = (m_owner == 0) || mem_ready_i;
    if (imem_valid_i) iq.push_back('{addr: imem_addr_i, wdata: 32'h0, wstrb: 4'h0, fence: imem_fence_i, instr: 1'b1});
    if (dmem_valid_i) dq.push_back('{addr: dmem_addr_i, wdata: dmem_wdata_i, wstrb: dmem_wstrb_i, fence: dmem_fence_i, instr: 1'b0});
    ic = iq.size() != 0;
    dc = dq.size() != 0;
    win = 0;
    if (gt) begin
      if (ic && dc) begin
`ifdef ARBITER_ROUND_ROBIN_EN
        win = m_rr ? 1 : 2;
        m_rr = !m_rr;
`else
        win = (m_streak == LIMIT) ? 1 : 2;
`endif
      end else if (ic) win = 1;
      else if (dc) win = 2;
      if (win == 1) t = iq.pop_front();
      else if (win == 2) t = dq.pop_front();
      if (win != 0) begin
        mv = 1; mi = t.instr; mf = t.fence; ma = t.addr; mw = t.wdata; ms = t.wstrb;
      end
      m_owner = win;
    end
`ifndef ARBITER_ROUND_ROBIN_EN
    if (win == 1 || !ic) m_streak = 0;
    else if (win == 2 && m_streak < LIMIT) m_streak++;
`endif
    e = {mv, mi, mf, ma, mw, ms, ir, id, dr, dd};
  endtask

  initial begin
    vec_t tbl[28];
    logic [OW-1:0] exp;
    logic [5:0] starve_order;
    bit i_busy, d_busy, icomp, dcomp;
    int owner_now;

    // rs iv ia ifn | dv da dw ds dfn | mr mrd || ev ei ef ea ew es | eir eid edr edd
    tbl[0]  = mk(0,0,0,0, 0,0,0,0,0, 0,0,             0,0,0,0,0,0, 0,0,0,0);
    tbl[1]  = mk(0,0,0,0, 0,0,0,0,0, 1,32'h99,        0,0,0,0,0,0, 0,0,0,0);
    tbl[2]  = mk(1,0,0,0, 1,32'h100,0,0,0, 0,0,       1,0,0,32'h100,0,0, 0,0,0,0);
    tbl[3]  = mk(1,0,0,0, 0,0,0,0,0, 0,0,             0,0,0,0,0,0, 0,0,0,0);
    tbl[4]  = mk(1,0,0,0, 0,0,0,0,0, 0,0,             0,0,0,0,0,0, 0,0,0,0);
    tbl[5]  = mk(1,0,0,0, 0,0,0,0,0, 1,32'hDEADBEEF,  0,0,0,0,0,0, 0,0,1,32'hDEADBEEF);
    tbl[6]  = mk(1,0,0,0, 0,0,0,0,0, 1,32'h55,        0,0,0,0,0,0, 0,0,0,0);
    tbl[7]  = mk(1,1,32'h0,0, 1,32'h200,32'h12345678,4'hF,0, 0,0, 1,0,0,32'h200,32'h12345678,4'hF, 0,0,0,0);
    tbl[8]  = mk(1,0,0,0, 0,0,0,0,0, 0,0,             0,0,0,0,0,0, 0,0,0,0);
    tbl[9]  = mk(1,0,0,0, 0,0,0,0,0, 1,32'h0,         1,1,0,32'h0,0,0, 0,0,1,0);
    tbl[10] = mk(1,0,0,0, 0,0,0,0,0, 1,32'hCAFE0001,  0,0,0,0,0,0, 1,32'hCAFE0001,0,0);
    tbl[11] = mk(1,1,32'h40,0, 0,0,0,0,0, 0,0,        1,1,0,32'h40,0,0, 0,0,0,0);
    tbl[12] = mk(1,0,0,0, 1,32'h300,0,0,1, 0,0,       0,0,0,0,0,0, 0,0,0,0);
    tbl[13] = mk(1,0,0,0, 0,0,0,0,0, 0,0,             0,0,0,0,0,0, 0,0,0,0);
    tbl[14] = mk(1,0,0,0, 0,0,0,0,0, 1,32'h11,        1,0,1,32'h300,0,0, 1,32'h11,0,0);
    tbl[15] = mk(1,0,0,0, 0,0,0,0,0, 0,0,             0,0,0,0,0,0, 0,0,0,0);
    tbl[16] = mk(1,0,0,0, 0,0,0,0,0, 1,32'h0,         0,0,0,0,0,0, 0,0,1,0);
    tbl[17] = mk(1,0,0,0, 1,32'h400,32'hA5A5A5A5,4'h3,0, 0,0, 1,0,0,32'h400,32'hA5A5A5A5,4'h3, 0,0,0,0);
    tbl[18] = mk(1,0,0,0, 1,32'h404,32'h1,4'h1,0, 1,32'h22, 1,0,0,32'h404,32'h1,4'h1, 0,0,1,32'h22);
    tbl[19] = mk(1,0,0,0, 0,0,0,0,0, 1,32'h33,        0,0,0,0,0,0, 0,0,1,32'h33);
    tbl[20] = mk(1,0,0,0, 1,32'h500,0,0,0, 0,0,       1,0,0,32'h500,0,0, 0,0,0,0);
    tbl[21] = mk(1,1,32'h80,0, 0,0,0,0,0, 0,0,        0,0,0,0,0,0, 0,0,0,0);
    tbl[22] = mk(0,0,0,0, 0,0,0,0,0, 1,32'h99,        0,0,0,0,0,0, 0,0,0,0);
    tbl[23] = mk(1,0,0,0, 0,0,0,0,0, 0,0,             0,0,0,0,0,0, 0,0,0,0);
    tbl[24] = mk(1,0,0,0, 0,0,0,0,0, 1,32'h77,        0,0,0,0,0,0, 0,0,0,0);
    tbl[25] = mk(1,0,0,0, 0,0,0,0,0, 0,0,             0,0,0,0,0,0, 0,0,0,0);
    tbl[26] = mk(1,1,32'h60,1, 0,0,0,0,0, 0,0,        1,1,1,32'h60,0,0, 0,0,0,0);
    tbl[27] = mk(1,0,0,0, 0,0,0,0,0, 1,32'h5,         0,0,0,0,0,0, 1,32'h5,0,0);

    drive_zero();
    rst = 0;
    @(posedge clk); #1;

    for (int i = 0; i < 28; i++) begin
      rst = tbl[i].rs;
      imem_valid_i = tbl[i].iv; imem_addr_i = tbl[i].ia; imem_fence_i = tbl[i].ifn;
      dmem_valid_i = tbl[i].dv; dmem_addr_i = tbl[i].da; dmem_wdata_i = tbl[i].dw;
      dmem_wstrb_i = tbl[i].ds; dmem_fence_i = tbl[i].dfn;
      mem_ready_i = tbl[i].mr; mem_rdata_i = tbl[i].mrd;
      exp = {tbl[i].ev, tbl[i].ei, tbl[i].ef, tbl[i].ea, tbl[i].ew, tbl[i].es,
             tbl[i].eir, tbl[i].eid, tbl[i].edr, tbl[i].edd};
      apply_check(exp, $sformatf("tbl[%0d]", i));
    end

    reset_all();
`ifdef ARBITER_ROUND_ROBIN_EN
    imem_valid_i = 1; imem_addr_i = 32'h2000; dmem_valid_i = 1; dmem_addr_i = 32'hE00;
    seq_check(1, 0, "rr0");
    imem_valid_i = 0; dmem_valid_i = 1; mem_ready_i = 1;
    seq_check(1, 1, "rr1");
    imem_valid_i = 1; dmem_valid_i = 0; mem_ready_i = 1;
    seq_check(1, 0, "rr2");
    imem_valid_i = 0; dmem_valid_i = 1; mem_ready_i = 1;
    seq_check(1, 1, "rr3");
`else
    starve_order = 6'b010000;
    imem_valid_i = 1; imem_addr_i = 32'h1000; dmem_valid_i = 1; dmem_addr_i = 32'hD00;
    seq_check(1, starve_order[0], "starve0");
    imem_valid_i = 0;
    for (int c = 1; c <= 5; c++) begin
      mem_ready_i = 1;
      dmem_valid_i = (c < 5);
      dmem_addr_i = 32'hD00 + 32'(c * 4);
      seq_check(1, starve_order[c], $sformatf("starve%0d", c));
    end
    imem_valid_i = 1; dmem_valid_i = 1; mem_ready_i = 1;
    seq_check(1, 0, "starve_cleared");
`endif

    reset_all();
    i_busy = 0;
    d_busy = 0;
    for (int n = 0; n < 4000; n++) begin
      owner_now = m_owner;
      rst = ($urandom_range(0, 199) != 0);
      mem_ready_i = (owner_now != 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
      mem_rdata_i = $urandom;
      icomp = rst && owner_now == 1 && mem_ready_i;
      dcomp = rst && owner_now == 2 && mem_ready_i;
      imem_valid_i = rst && (!i_busy || icomp) && ($urandom_range(0, 1) == 0);
      imem_addr_i = $urandom & 32'hFFFF_FFFC;
      imem_fence_i = ($urandom_range(0, 7) == 0);
      dmem_valid_i = rst && (!d_busy || dcomp) && ($urandom_range(0, 1) == 0);
      dmem_addr_i = $urandom & 32'hFFFF_FFFC;
      dmem_wdata_i = $urandom;
      dmem_wstrb_i = 4'($urandom_range(0, 15));
      dmem_fence_i = ($urandom_range(0, 7) == 0);
      model_step(exp);
      if (!rst) begin
        i_busy = 0;
        d_busy = 0;
      end else begin
        if (imem_valid_i) i_busy = 1; else if (icomp) i_busy = 0;
        if (dmem_valid_i) d_busy = 1; else if (dcomp) d_busy = 0;
      end
      apply_check(exp, $sformatf("rand[%0d]", n));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-to-one arbiter merging the instruction port and the data port into a single memory bus.
- The data port is the output of the write buffer.
- Sits directly downstream of the write buffer and upstream of the shared memory/bus interface.
- Captures single-cycle request pulses from each master, grants exactly one outstanding transaction to memory at a time, and routes the response back to the owner.

Parameters:
starve_limit, 4, max consecutive data grants while an instruction request is pending before the instruction request is forced to win (fixed-priority mode only); range 1..15

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-low
imem_in  input  mem_in_type  instruction-side request (mem_valid pulse, mem_addr, mem_fence)
imem_out  output  mem_out_type  instruction-side response (mem_rdata, mem_ready)
dmem_in  input  mem_in_type  data-side request from write buffer (mem_valid, mem_fence, mem_addr, mem_wdata, mem_wstrb)
dmem_out  output  mem_out_type  data-side response to write buffer
mem_in  output  mem_in_type  request to shared memory
mem_out  input  mem_out_type  response from shared memory

Behaviour:
- Reset (rst=0 at posedge): state IDLE; both pending slots invalid; starvation counter 0; rr pointer 0. All outputs are 0 during and after reset until a new request arrives.
- Request protocol:
  - mem_valid is a one-cycle pulse per transaction.
  - Each master holds at most one transaction in flight until it sees mem_ready.
  - A pulse is captured into that port's pending slot: addr, wdata, wstrb, fence; instr=1 for the imem slot, 0 for the dmem slot.
- States:
  - IDLE: no transaction outstanding.
  - BUSY_I: instruction transaction outstanding.
  - BUSY_D: data transaction outstanding.
- Grant point:
  - A grant occurs in any cycle where the state is IDLE, or the state is BUSY and mem_out.mem_ready=1 (back-to-back issue).
  - Candidates are pending slots plus same-cycle incoming pulses.
  - An incoming pulse bypasses its slot combinationally, so a lone request in IDLE appears on mem_in in the same cycle (zero added latency).
- Grant issue:
  - mem_in.mem_valid=1 for exactly one cycle.
  - mem_in carries the winner's fields; mem_instr=1 for an instruction grant.
  - The winner's slot is cleared; state becomes BUSY_I or BUSY_D.
  - With no candidate, the state returns to IDLE and mem_in fields are driven 0.
- Fixed priority (default):
  - Data wins over instruction.
  - The counter increments on each data grant while an instruction candidate exists, and saturates at starve_limit.
  - When counter==starve_limit, instruction wins the next contested grant.
  - The counter clears on any instruction grant, and whenever no instruction candidate exists.
- Response routing:
  - While BUSY_I, imem_out.mem_rdata/mem_ready follow mem_out combinationally, and dmem_out is held 0. BUSY_D is symmetric.
  - In IDLE both responses are 0.
- Fences: dmem fence and imem fence are forwarded as ordinary transactions with mem_fence=1; completion is the memory's mem_ready.
- Boundary conditions:
  - Simultaneous pulses on both ports with IDLE and nothing pending: one is issued, the other is captured and issued on the first mem_ready.
  - A pulse from the owner in the same cycle as its own mem_ready is legal and becomes a candidate in that grant.
  - A second pulse from a port whose slot is already full, or whose transaction is outstanding without ready, is a protocol violation. The new pulse is dropped, the first is kept, and a simulation-only error is reported.
  - Reset mid-transaction drops the outstanding transaction and both slots. No response is delivered afterwards; mem_ready arriving after reset is ignored because the state is IDLE.

Optional Feature:
- Macro ARBITER_ROUND_ROBIN_EN.
- Defined:
  - The starvation counter and starve_limit are unused.
  - A 1-bit rr pointer selects the preferred port on contested grants and toggles to the other port after every contested grant.
  - The reset preference is data.
- Undefined: fixed data priority with starvation limit as in Behaviour.

Test Plan:
- Single data read: dmem pulse addr=0x100, wstrb=0 in IDLE -> mem_in.mem_valid=1 same cycle, mem_instr=0, addr=0x100. Memory returns rdata=0xDEADBEEF, ready after 3 cycles -> dmem_out ready/rdata that cycle; imem_out stays 0.
- Simultaneous requests: imem addr=0x0 and dmem store addr=0x200, wdata=0x12345678, wstrb=0xF in the same cycle -> data issued first. On its mem_ready, imem issued in that same cycle with mem_instr=1, addr=0x0.
- Starvation, starve_limit=4: imem pending plus 5 back-to-back dmem requests -> grants in order D,D,D,D,I,D; counter returns to 0 after the I grant.
- Fence: dmem pulse mem_fence=1 while BUSY_I -> held until imem ready, then issued with mem_fence=1. dmem_out.mem_ready only on the fence's ready.
- Reset mid-operation: rst=0 while BUSY_D with imem pending -> next cycle all outputs 0. A later mem_out.mem_ready=1 produces no response on either port.
- Round-robin (ARBITER_ROUND_ROBIN_EN defined): 4 contested grants with both ports always requesting -> order D,I,D,I.
